// File: rtl/csr_pkg.sv
// csr_pkg: shared CSR addresses, bit positions, op encoding and trap vector
package csr_pkg;
  localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
  localparam logic [11:0] ADDR_MIE      = 12'h304;
  localparam logic [11:0] ADDR_MTVEC    = 12'h305;
  localparam logic [11:0] ADDR_MEPC     = 12'h341;
  localparam logic [11:0] ADDR_MIP      = 12'h344;
  localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;
  localparam logic [11:0] ADDR_MINSTRET = 12'hB02;
  localparam logic [11:0] ADDR_MCYCLEH  = 12'hB80;
  localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
  localparam int MIE_BIT  = 3;
  localparam int MPIE_BIT = 7;
  localparam int MTIE_BIT = 7;
  localparam int MEIE_BIT = 11;
  localparam int MTIP_BIT = 7;
  localparam int MEIP_BIT = 11;
  localparam logic [31:0] MTVEC_BASE = 32'h0001_0000;
  typedef enum logic [1:0] {
    CSR_NOP = 2'b00,
    CSR_RW  = 2'b01,
    CSR_RS  = 2'b10,
    CSR_RC  = 2'b11
  } csr_op_e;
endpackage

// File: rtl/csr_counter64.sv
// csr_counter64: 64-bit wrapping counter with enable
module csr_counter64 (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [63:0] cnt
);
  logic [63:0] cnt_q, cnt_d;
  always_comb cnt_d = en ? cnt_q + 64'd1 : cnt_q;
  always_ff @(posedge clk)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign cnt = cnt_q;
endmodule

// File: rtl/csr_trap_unit.sv
// csr_trap_unit: machine-mode CSRs, counters, trap entry/return and fetch redirect
module csr_trap_unit
  import csr_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        csr_we,
  input  logic [1:0]  csr_op,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_rdata,
  input  logic [31:0] trap_pc,
  input  logic        instret_inc,
  input  logic        MEIP_en,
  input  logic        MEIP_end,
  input  logic        MTIP_en,
  input  logic        MTIP_end,
  input  logic        WFI_out,
  output logic        mie_out,
  output logic        meie_out,
  output logic        mtie_out,
  output logic        trap_redirect,
  output logic [31:0] trap_target
);
  logic        mie_q, mie_d, mpie_q, mpie_d, meie_q, meie_d, mtie_q, mtie_d;
  logic        meip_q, meip_d, mtip_q, mtip_d, redir_q, redir_d;
  logic [31:0] mepc_q, mepc_d, target_q, target_d;
  logic [31:0] mstatus_v, mie_v, mip_v, wval;
  logic [63:0] mcycle, minstret;
  logic        entry, ret, wr_en;
  csr_op_e     op;
  assign op    = csr_op_e'(csr_op);
  assign entry = !stall && (MEIP_en || MTIP_en);
  assign ret   = !stall && !entry && (MEIP_end || MTIP_end);
  assign wr_en = csr_we && op != CSR_NOP && !stall && !entry && !ret;
  csr_counter64 u_mcycle (.clk(clk), .rst(rst), .en(1'b1), .cnt(mcycle));
  csr_counter64 u_minstret (.clk(clk), .rst(rst), .en(instret_inc && !stall && !WFI_out), .cnt(minstret));
  always_comb begin
    mstatus_v = '0;
    mstatus_v[12:11] = 2'b11;
    mstatus_v[MPIE_BIT] = mpie_q;
    mstatus_v[MIE_BIT] = mie_q;
    mie_v = '0;
    mie_v[MEIE_BIT] = meie_q;
    mie_v[MTIE_BIT] = mtie_q;
    mip_v = '0;
    mip_v[MEIP_BIT] = meip_q;
    mip_v[MTIP_BIT] = mtip_q;
    case (csr_addr)
      ADDR_MSTATUS:   csr_rdata = mstatus_v;
      ADDR_MIE:       csr_rdata = mie_v;
      ADDR_MTVEC:     csr_rdata = MTVEC_BASE;
      ADDR_MEPC:      csr_rdata = mepc_q;
      ADDR_MIP:       csr_rdata = mip_v;
      ADDR_MCYCLE:    csr_rdata = mcycle[31:0];
      ADDR_MCYCLEH:   csr_rdata = mcycle[63:32];
      ADDR_MINSTRET:  csr_rdata = minstret[31:0];
      ADDR_MINSTRETH: csr_rdata = minstret[63:32];
      default:        csr_rdata = '0;
    endcase
  end
  always_comb begin
    wval = op == CSR_RW ? csr_wdata :
           op == CSR_RS ? csr_rdata | csr_wdata :
           op == CSR_RC ? csr_rdata & ~csr_wdata : csr_rdata;
    mie_d  = entry ? 1'b0 : ret ? mpie_q :
             wr_en && csr_addr == ADDR_MSTATUS ? wval[MIE_BIT] : mie_q;
    mpie_d = entry ? mie_q : ret ? 1'b1 :
             wr_en && csr_addr == ADDR_MSTATUS ? wval[MPIE_BIT] : mpie_q;
    meie_d = wr_en && csr_addr == ADDR_MIE ? wval[MEIE_BIT] : meie_q;
    mtie_d = wr_en && csr_addr == ADDR_MIE ? wval[MTIE_BIT] : mtie_q;
    meip_d = entry && MEIP_en ? 1'b1 : ret && MEIP_end ? 1'b0 : meip_q;
    mtip_d = entry && !MEIP_en ? 1'b1 : ret && MTIP_end ? 1'b0 : mtip_q;
    mepc_d = entry ? trap_pc & ~32'h3 :
             wr_en && csr_addr == ADDR_MEPC ? wval & ~32'h3 : mepc_q;
    redir_d  = entry || ret ? 1'b1 : stall ? redir_q : 1'b0;
    target_d = entry ? MTVEC_BASE : ret ? mepc_q : target_q;
  end
  always_ff @(posedge clk)
    if (rst) begin
      mie_q    <= 1'b0;
      mpie_q   <= 1'b0;
      meie_q   <= 1'b0;
      mtie_q   <= 1'b0;
      meip_q   <= 1'b0;
      mtip_q   <= 1'b0;
      mepc_q   <= '0;
      redir_q  <= 1'b0;
      target_q <= '0;
    end else begin
      mie_q    <= mie_d;
      mpie_q   <= mpie_d;
      meie_q   <= meie_d;
      mtie_q   <= mtie_d;
      meip_q   <= meip_d;
      mtip_q   <= mtip_d;
      mepc_q   <= mepc_d;
      redir_q  <= redir_d;
      target_q <= target_d;
    end
  assign mie_out       = mie_q;
  assign meie_out      = meie_q;
  assign mtie_out      = mtie_q;
  assign trap_redirect = redir_q;
  assign trap_target   = target_q;
endmodule
